dff_pipe_chain: RTL and testbench

//   Parametrised chain of D-type registers (delay line) with synchronous active-high reset,

---
 rtl/dff_pipe_chain.sv | 75 +++++++
 tb/tb_dff_pipe_chain.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe_chain.sv
// Parametrised delay line of DEPTH register stages with per-stage valid bits,
// stall enable, flush, a selectable tap and a registered occupancy count.
module dff_pipe_chain #(
    parameter int              WIDTH   = 8,
    parameter int              DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int             TW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int             CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic [TW-1:0]    tap_sel,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [CW-1:0]    occupancy
);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [CW-1:0]    occ;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
            vld <= '0;
            occ <= '0;
        end else if (flush) begin
            vld <= '0;
            occ <= '0;
        end else if (en) begin
            stage[0] <= d;
            vld[0]   <= d_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
                vld[i]   <= vld[i-1];
            end
            // One word enters and one leaves per shift, so occupancy moves by at most one.
            if (d_valid && !vld[DEPTH-1]) begin
                occ <= occ + CW'(1);
            end else if (!d_valid && vld[DEPTH-1]) begin
                occ <= occ - CW'(1);
            end
        end
    end

    assign q         = stage[DEPTH-1];
    assign q_valid   = vld[DEPTH-1];
    assign occupancy = occ;

    // Tap table padded to a power of two so every tap_sel code maps to a defined value.
    logic [WIDTH-1:0] tap_data [2**TW];
    logic [2**TW-1:0] tap_vld;

    for (genvar g = 0; g < 2**TW; g++) begin : g_tap
        if (g < DEPTH) begin : g_real
            assign tap_data[g] = stage[g];
            assign tap_vld[g]  = vld[g];
        end else begin : g_pad
            assign tap_data[g] = RST_VAL;
            assign tap_vld[g]  = 1'b0;
        end
    end

    assign tap_q     = tap_data[tap_sel];
    assign tap_valid = tap_vld[tap_sel];

endmodule

// File: tb/tb_dff_pipe_chain.sv
// Bench for dff_pipe_chain: four instances (DEPTH 4/4/1/3, one with RST_VAL 5A)
// share one stimulus stream and are compared against a delay-line model.
module tb_dff_pipe_chain;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic [7:0] d;
    logic       d_valid;
    logic [1:0] tsel;

    logic [7:0] q0, q1, q2, q3;
    logic       qv0, qv1, qv2, qv3;
    logic [7:0] tq0, tq1, tq2, tq3;
    logic       tv0, tv1, tv2, tv3;
    logic [2:0] occ0, occ1;
    logic [0:0] occ2;
    logic [1:0] occ3;

    int checks = 0;
    int errors = 0;

    dff_pipe_chain #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h00)) u0 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q0), .q_valid(qv0), .tap_sel(tsel), .tap_q(tq0), .tap_valid(tv0), .occupancy(occ0));
    dff_pipe_chain #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h5A)) u1 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q1), .q_valid(qv1), .tap_sel(tsel), .tap_q(tq1), .tap_valid(tv1), .occupancy(occ1));
    dff_pipe_chain #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00)) u2 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q2), .q_valid(qv2), .tap_sel(tsel[0:0]), .tap_q(tq2), .tap_valid(tv2), .occupancy(occ2));
    dff_pipe_chain #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00)) u3 (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .d(d), .d_valid(d_valid),
        .q(q3), .q_valid(qv3), .tap_sel(tsel), .tap_q(tq3), .tap_valid(tv3), .occupancy(occ3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [7:0] oq  [4];
    logic [7:0] oqv [4];
    logic [7:0] otq [4];
    logic [7:0] otv [4];
    logic [7:0] ooc [4];
    assign oq[0] = q0;  assign oq[1] = q1;  assign oq[2] = q2;  assign oq[3] = q3;
    assign oqv[0] = {7'b0, qv0}; assign oqv[1] = {7'b0, qv1};
    assign oqv[2] = {7'b0, qv2}; assign oqv[3] = {7'b0, qv3};
    assign otq[0] = tq0; assign otq[1] = tq1; assign otq[2] = tq2; assign otq[3] = tq3;
    assign otv[0] = {7'b0, tv0}; assign otv[1] = {7'b0, tv1};
    assign otv[2] = {7'b0, tv2}; assign otv[3] = {7'b0, tv3};
    assign ooc[0] = {5'b0, occ0}; assign ooc[1] = {5'b0, occ1};
    assign ooc[2] = {7'b0, occ2}; assign ooc[3] = {6'b0, occ3};

    // Model: each instance is a row of words; index 0 is the newest word.
    int         dep  [4] = '{4, 4, 1, 3};
    logic [7:0] rstv [4] = '{8'h00, 8'h5A, 8'h00, 8'h00};
    logic [7:0] mdat [4][4];
    logic       mvld [4][4];

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[u%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                for (int i = 0; i < 4; i++) begin
                    mdat[k][i] = rstv[k];
                    mvld[k][i] = 1'b0;
                end
            end else if (flush) begin
                for (int i = 0; i < 4; i++) mvld[k][i] = 1'b0;
            end else if (en) begin
                for (int i = dep[k] - 1; i > 0; i--) begin
                    mdat[k][i] = mdat[k][i-1];
                    mvld[k][i] = mvld[k][i-1];
                end
                mdat[k][0] = d;
                mvld[k][0] = d_valid;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            int sel;
            int cnt;
            sel = (k == 2) ? int'(tsel[0]) : int'(tsel);
            cnt = 0;
            for (int i = 0; i < dep[k]; i++) if (mvld[k][i]) cnt++;
            chk("q", k, oq[k], mdat[k][dep[k]-1]);
            chk("q_valid", k, oqv[k], {7'b0, mvld[k][dep[k]-1]});
            chk("occupancy", k, ooc[k], 8'(cnt));
            chk("tap_q", k, otq[k], (sel < dep[k]) ? mdat[k][sel] : rstv[k]);
            chk("tap_valid", k, otv[k], (sel < dep[k]) ? {7'b0, mvld[k][sel]} : 8'h00);
        end
    endtask

    task automatic sweep_taps();
        for (int s = 0; s < 4; s++) begin
            tsel = 2'(s);
            #1;
            check_all();
        end
        tsel = 2'd0;
    endtask

    logic [7:0] pat [4] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F};
    logic [7:0] occ_exp [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};

    initial begin
        rst = 1'b1; en = 1'b0; flush = 1'b0; d = 8'h00; d_valid = 1'b0; tsel = 2'd0;
        tick();

        // 1: reset over stale contents
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom); d_valid = 1'b1; tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_q", 0, q0, 8'h00);
        chk("rst_occ", 0, ooc[0], 8'h00);
        sweep_taps();

        // 2: latency and occupancy through a 4-word burst
        en = 1'b1;
        for (int e = 0; e < 8; e++) begin
            d       = (e < 4) ? pat[e] : 8'h00;
            d_valid = (e < 4);
            tick();
            check_all();
            chk("lat_occ", 0, ooc[0], occ_exp[e]);
            if (e >= 3 && e <= 6) begin
                chk("lat_q", 0, q0, pat[e-3]);
                chk("lat_qv", 0, oqv[0], 8'h01);
            end
        end
        chk("lat_qv_end", 0, oqv[0], 8'h00);

        // 3: stall holds everything, then resume
        rst = 1'b1; tick(); rst = 1'b0;
        en = 1'b1; d = 8'hA5; d_valid = 1'b1; tick();
        d = 8'h3C; tick();
        en = 1'b0; d = 8'hEE;
        tsel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all();
            chk("stall_occ", 0, ooc[0], 8'd2);
            chk("stall_tap", 0, tq0, 8'hA5);
        end
        en = 1'b1; d_valid = 1'b0; tsel = 2'd0;
        tick(); check_all();
        tick(); check_all();
        chk("stall_exit_q", 0, q0, 8'hA5);
        chk("stall_exit_qv", 0, oqv[0], 8'h01);
        tick(); check_all();
        chk("stall_order", 0, q0, 8'h3C);

        // 4: flush wins over enable and drops the incoming word
        for (int i = 0; i < 4; i++) begin
            d = 8'h10 + 8'(i); d_valid = 1'b1; tick();
        end
        chk("full_occ", 0, ooc[0], 8'd4);
        flush = 1'b1; d = 8'h77; d_valid = 1'b1;
        tick();
        flush = 1'b0; d_valid = 1'b0;
        check_all();
        chk("flush_occ", 0, ooc[0], 8'd0);
        chk("flush_tap0", 0, tq0, 8'h13);
        chk("flush_tv0", 0, otv[0], 8'h00);

        // 5: reset mid-stream with enable and valid input
        d = 8'h21; d_valid = 1'b1; tick();
        d = 8'h22; tick();
        chk("mid_occ", 0, ooc[0], 8'd2);
        rst = 1'b1; d = 8'h99; tick();
        rst = 1'b0; d_valid = 1'b0;
        chk("mid_rst_q5a", 1, q1, 8'h5A);
        sweep_taps();

        // 6: saturation under continuous valid input
        en = 1'b1; d_valid = 1'b1; tsel = 2'd3;
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom); tick(); check_all();
        end
        chk("sat_occ3", 3, ooc[3], 8'd3);
        chk("tap_pad3", 3, tq3, 8'h00);
        chk("dep1_q", 2, q2, d);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 59) == 0);
            flush   = ($urandom_range(0, 24) == 0);
            en      = ($urandom_range(0, 3) != 0);
            d       = 8'($urandom);
            d_valid = 1'($urandom);
            tsel    = 2'($urandom);
            tick();
            check_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
